pu_syntax_seq: RTL and testbench

PU_SYNTAX_SEQ -- requirements
Module: pu_syntax_seq

---
 rtl/pu_syntax_seq_pkg.sv | 56 +++++
 rtl/pu_syntax_seq_bincnt.sv | 34 +++
 rtl/pu_syntax_seq.sv | 123 ++++++++++++
 tb/tb_pu_syntax_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_syntax_seq_pkg.sv
// Shared codes, types and next-element selection for the PU syntax sequencer.
package pu_syntax_seq_pkg;

    localparam logic [2:0] SE_MERGE_FLAG = 3'd0;
    localparam logic [2:0] SE_MERGE_IDX  = 3'd1;
    localparam logic [2:0] SE_IPI        = 3'd2;
    localparam logic [2:0] SE_REF0       = 3'd3;
    localparam logic [2:0] SE_MVP0       = 3'd4;
    localparam logic [2:0] SE_REF1       = 3'd5;
    localparam logic [2:0] SE_MVP1       = 3'd6;
    localparam logic [2:0] SE_DONE       = 3'd7;

    localparam logic [1:0] PRED_L0      = 2'd0;
    localparam logic [1:0] PRED_L1      = 2'd1;
    localparam logic [1:0] PRED_BI      = 2'd2;
    localparam logic [1:0] PRED_ILLEGAL = 2'd3;

    localparam logic [4:0] TIMEOUT_MAX = 5'd31;
    localparam logic [4:0] BIN_MAX     = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       merge;
        logic       b_slice;
        logic [1:0] dir;
        logic       ref0_nz;
        logic       ref1_nz;
    } pu_fields_t;

    // Candidates are tested from the back of the order so the earliest enabled one wins.
    function automatic logic [2:0] next_se(input logic [2:0] cur, input pu_fields_t f);
        logic [2:0] nxt;
        logic       use0;
        logic       use1;
        nxt  = SE_DONE;
        use0 = (f.dir == PRED_L0) || (f.dir == PRED_BI);
        use1 = (f.dir == PRED_L1) || (f.dir == PRED_BI);
        if (cur == SE_MERGE_FLAG && f.merge) begin
            nxt = SE_MERGE_IDX;
        end else if (cur != SE_MERGE_IDX) begin
            if (cur < SE_MVP1 && use1)              nxt = SE_MVP1;
            if (cur < SE_REF1 && use1 && f.ref1_nz) nxt = SE_REF1;
            if (cur < SE_MVP0 && use0)              nxt = SE_MVP0;
            if (cur < SE_REF0 && use0 && f.ref0_nz) nxt = SE_REF0;
            if (cur < SE_IPI && f.b_slice)          nxt = SE_IPI;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pu_syntax_seq_bincnt.sv
// Saturating bin counter for one PU: cleared at accept, incremented per bin strobe.
module pu_syntax_seq_bincnt
    import pu_syntax_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [4:0] cnt_o
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && cnt_q != BIN_MAX) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pu_syntax_seq.sv
// PU syntax-element sequencer: issues one binarizer request per element and
// waits for its done pulse, with a per-element timeout and a bin counter.
module pu_syntax_seq
    import pu_syntax_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pu_valid,
    output logic       pu_ready,
    input  logic       merge_flag,
    input  logic [1:0] inter_pred_idc,
    input  logic       slice_is_b,
    input  logic [3:0] num_ref_l0_m1,
    input  logic [3:0] num_ref_l1_m1,
    output logic       se_start,
    output logic [2:0] se_id,
    input  logic       se_done,
    input  logic       bin_valid_in,
    output logic       pu_done,
    output logic [4:0] pu_bins,
    output logic       pu_err
);

    state_t     state_q, state_d;
    logic [4:0] tmo_q, tmo_d;
    logic [2:0] se_id_q, se_id_d;
    logic [2:0] nxt_se;
    pu_fields_t fields_q, fields_d;
    logic       err_q, err_d;
    logic       ready_q;
    logic       accept;
    logic       illegal_ipi;

    // ready_q is only high in IDLE, so it alone qualifies an accept.
    assign accept      = pu_valid && ready_q;
    assign illegal_ipi = slice_is_b && (inter_pred_idc == PRED_ILLEGAL);

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        se_id_d  = se_id_q;
        fields_d = fields_q;
        err_d    = err_q;
        nxt_se   = SE_DONE;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    fields_d.merge   = merge_flag;
                    fields_d.b_slice = slice_is_b;
                    fields_d.dir     = (slice_is_b && !illegal_ipi) ? inter_pred_idc : PRED_L0;
                    fields_d.ref0_nz = |num_ref_l0_m1;
                    fields_d.ref1_nz = |num_ref_l1_m1;
                    err_d            = illegal_ipi;
                    se_id_d          = SE_MERGE_FLAG;
                    tmo_d            = '0;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (se_done) begin
                    nxt_se = next_se(se_id_q, fields_q);
                    if (nxt_se == SE_DONE) begin
                        state_d = ST_DONE;
                    end else begin
                        se_id_d = nxt_se;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    tmo_d = tmo_q + 5'd1;
                    if (tmo_q == TIMEOUT_MAX - 5'd1) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            se_id_q <= SE_MERGE_FLAG;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            se_id_q <= se_id_d;
            err_q   <= err_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        fields_q <= fields_d;
    end

    pu_syntax_seq_bincnt u_bincnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .inc_i (bin_valid_in && (state_q == ST_ISSUE || state_q == ST_WAIT)),
        .cnt_o (pu_bins)
    );

    assign pu_ready = ready_q;
    assign se_start = (state_q == ST_ISSUE);
    assign se_id    = se_id_q;
    assign pu_done  = (state_q == ST_DONE);
    assign pu_err   = err_q;

endmodule

// File: tb/tb_pu_syntax_seq.sv
// Randomized scoreboard bench for pu_syntax_seq with a behavioural binarizer responder.
`timescale 1ns/1ps
module tb_pu_syntax_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pu_valid = 1'b0;
    logic       merge_flag = 1'b0;
    logic [1:0] inter_pred_idc = 2'd0;
    logic       slice_is_b = 1'b0;
    logic [3:0] num_ref_l0_m1 = 4'd0;
    logic [3:0] num_ref_l1_m1 = 4'd0;
    logic       se_done = 1'b0;
    logic       bin_valid_in = 1'b0;
    logic       pu_ready;
    logic       se_start;
    logic [2:0] se_id;
    logic       pu_done;
    logic [4:0] pu_bins;
    logic       pu_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_id_q[$];
    bit exp_err_q[$];
    int acc_cyc = 0;
    int exp_busy = 0;
    int bins_sent = 0;
    bit hang_en = 0;
    int hang_id = 0;
    bit spur_en = 0;
    bit fixed2 = 0;

    pu_syntax_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pu_valid       (pu_valid),
        .pu_ready       (pu_ready),
        .merge_flag     (merge_flag),
        .inter_pred_idc (inter_pred_idc),
        .slice_is_b     (slice_is_b),
        .num_ref_l0_m1  (num_ref_l0_m1),
        .num_ref_l1_m1  (num_ref_l1_m1),
        .se_start       (se_start),
        .se_id          (se_id),
        .se_done        (se_done),
        .bin_valid_in   (bin_valid_in),
        .pu_done        (pu_done),
        .pu_bins        (pu_bins),
        .pu_err         (pu_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Binarizer model: done arrives rem cycles after start; a hung element never answers.
    initial begin : responder
        int  rem;
        int  waits;
        bit  active;
        bit  hang;
        rem = 0; waits = 0; active = 0; hang = 0;
        forever begin
            @(posedge clk); #1;
            se_done      = 1'b0;
            bin_valid_in = 1'b0;
            if (se_start) begin
                hang     = hang_en && (int'(se_id) == hang_id);
                rem      = fixed2 ? 2 : int'($urandom_range(1, 4));
                exp_busy += hang ? 32 : rem + 1;
                active   = 1;
                waits    = 0;
                if (spur_en && $urandom_range(0, 1) == 1) se_done = 1'b1;
            end else if (active) begin
                waits++;
                if ((!hang || waits <= 31) && $urandom_range(0, 2) != 0) begin
                    bin_valid_in = 1'b1;
                    bins_sent++;
                end
                if (!hang && waits == rem) begin
                    se_done = 1'b1;
                    active  = 0;
                end
                if (hang && waits >= 31) active = 0;
            end
        end
    end

    // Monitor: every start pulse and every pu_done is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (se_start) begin
                if (exp_id_q.size() == 0) check("se_start_unexpected", se_start, 0);
                else check("se_id", se_id, exp_id_q.pop_front());
            end
            if (pu_done) begin
                if (exp_err_q.size() == 0) begin
                    check("pu_done_unexpected", pu_done, 0);
                end else begin
                    check("pu_err", pu_err, exp_err_q.pop_front());
                    check("pu_bins", pu_bins, (bins_sent > 31) ? 31 : bins_sent);
                    check("done_latency", cyc - acc_cyc, 1 + exp_busy);
                    check("elements_left", exp_id_q.size(), 0);
                    check("pu_ready_at_done", pu_ready, 0);
                end
            end
        end
    end

    function automatic void model_seq(input bit m, input logic [1:0] ipi, input bit b,
                                      input logic [3:0] n0, input logic [3:0] n1,
                                      output int seq[$]);
        int dir;
        seq.delete();
        seq.push_back(0);
        if (m) begin
            seq.push_back(1);
        end else begin
            dir = (!b || ipi == 2'd3) ? 0 : int'(ipi);
            if (b) seq.push_back(2);
            if (dir == 0 || dir == 2) begin
                if (n0 != 0) seq.push_back(3);
                seq.push_back(4);
            end
            if (dir == 1 || dir == 2) begin
                if (n1 != 0) seq.push_back(5);
                seq.push_back(6);
            end
        end
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        while (pu_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("pu_ready_before_accept", pu_ready, 1);
    endtask

    task automatic drive_pu(input bit m, input logic [1:0] ipi, input bit b,
                            input logic [3:0] n0, input logic [3:0] n1,
                            input bit hg, input int hid, input bit spur, input bit f2);
        int seq[$];
        int idx;
        model_seq(m, ipi, b, n0, n1, seq);
        idx = -1;
        foreach (seq[i]) if (hg && seq[i] == hid && idx < 0) idx = i;
        if (idx < 0) hg = 0;
        else while (seq.size() > idx + 1) void'(seq.pop_back());
        wait_ready();
        hang_en = hg; hang_id = hid; spur_en = spur; fixed2 = f2;
        merge_flag = m; inter_pred_idc = ipi; slice_is_b = b;
        num_ref_l0_m1 = n0; num_ref_l1_m1 = n1;
        pu_valid = 1'b1;
        foreach (seq[i]) exp_id_q.push_back(seq[i]);
        exp_err_q.push_back(hg || (b && ipi == 2'd3));
        acc_cyc = cyc; exp_busy = 0; bins_sent = 0;
    endtask

    task automatic run_pu(input bit m, input logic [1:0] ipi, input bit b,
                          input logic [3:0] n0, input logic [3:0] n1,
                          input bit hg, input int hid, input bit spur, input bit f2, input bit poke);
        bit seen;
        drive_pu(m, ipi, b, n0, n1, hg, hid, spur, f2);
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (poke) begin
                pu_valid       = 1'($urandom_range(0, 1));
                merge_flag     = 1'($urandom_range(0, 1));
                inter_pred_idc = 2'($urandom_range(0, 3));
                slice_is_b     = 1'($urandom_range(0, 1));
                num_ref_l0_m1  = 4'($urandom_range(0, 15));
                num_ref_l1_m1  = 4'($urandom_range(0, 15));
            end else begin
                pu_valid = 1'b0;
            end
            if (pu_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        pu_valid = 1'b0;
        check("pu_done_seen", seen, 1);
        @(posedge clk); #1;
        check("pu_ready_after_done", pu_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pu_ready"}, pu_ready, 0);
        check({tag, "_se_start"}, se_start, 0);
        check({tag, "_se_id"},    se_id, 0);
        check({tag, "_pu_done"},  pu_done, 0);
        check({tag, "_pu_bins"},  pu_bins, 0);
        check({tag, "_pu_err"},   pu_err, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit found;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", pu_ready, 1);

        // Merge PU with 2-cycle binarizers: pu_done lands 7 edges after accept (8 cycles inclusive).
        run_pu(1, 2'd0, 1, 4'd3, 4'd3, 0, 0, 0, 1, 0);
        run_pu(0, 2'd2, 1, 4'd2, 4'd0, 0, 0, 0, 1, 0);
        run_pu(0, 2'd1, 0, 4'd1, 4'd5, 0, 0, 0, 0, 0);
        run_pu(0, 2'd1, 0, 4'd0, 4'd5, 0, 0, 0, 0, 0);
        run_pu(0, 2'd1, 1, 4'd0, 4'd7, 0, 0, 0, 0, 0);
        run_pu(0, 2'd3, 1, 4'd4, 4'd4, 0, 0, 0, 1, 0);
        run_pu(0, 2'd2, 1, 4'd2, 4'd0, 1, 3, 0, 1, 0);
        run_pu(0, 2'd2, 1, 4'd1, 4'd1, 0, 0, 1, 0, 1);

        // Reset during MVP0 abandons the PU.
        drive_pu(0, 2'd2, 1, 4'd1, 4'd1, 0, 0, 0, 1);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            pu_valid = 1'b0;
            if (se_start === 1'b1 && se_id == 3'd4) begin
                found = 1;
                break;
            end
        end
        check("mvp0_reached", found, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_id_q.delete();
        exp_err_q.delete();
        @(posedge clk); #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        check("no_done_in_reset", pu_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_reset", pu_ready, 1);
        run_pu(0, 2'd0, 1, 4'd1, 4'd0, 0, 0, 0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            run_pu(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                   $urandom_range(0, 6) == 0, int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_id_q.size() + exp_err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
